pc_unit: RTL and testbench

Program-counter stage sitting directly upstream of the instruction fetcher. Holds the architectural PC, drives it into the fetcher every cycle, applies stalls and branch redirects, and tags the fetcher's one-cycle-late instruction output with its address and a valid bit. Detects end of code memory and illegal branch targets, and reports run/done/fault status to the top-level control FSM.

---
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter stage: holds the architectural PC, steps or redirects it, and tags the
// fetcher's one-cycle-late instruction with its address and a valid bit. It also reports
// run/done/fault status to the control FSM.
module pc_unit #(
  parameter int BIT_WIDTH  = 32,
  parameter int INST_COUNT = 256,
  parameter int RESET_PC   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic [BIT_WIDTH-1:0] branch_target,
  output logic [BIT_WIDTH-1:0] pc,
  output logic [BIT_WIDTH-1:0] fetch_pc,
  output logic [BIT_WIDTH-1:0] pc_plus8,
  output logic                 inst_valid,
  output logic                 ready,
  output logic                 done,
  output logic                 fault
);

  localparam logic [BIT_WIDTH-1:0] MEM_BYTES = BIT_WIDTH'(INST_COUNT * 4);
  localparam logic [BIT_WIDTH-1:0] LAST_PC   = BIT_WIDTH'((INST_COUNT - 1) * 4);
  localparam logic [BIT_WIDTH-1:0] PC_STEP   = BIT_WIDTH'(4);
  localparam logic [BIT_WIDTH-1:0] R15_OFS   = BIT_WIDTH'(8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e                 state_q;
  logic [BIT_WIDTH-1:0]   pc_q;
  logic [BIT_WIDTH-1:0]   fetch_pc_q;
  logic                   inst_valid_q;
  logic                   target_legal;

  // A redirect is only accepted if it lands word-aligned inside code memory.
  assign target_legal = (branch_target[1:0] == 2'b00) && (branch_target < MEM_BYTES);

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= BIT_WIDTH'(RESET_PC);
      fetch_pc_q   <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      // The fetcher's output this cycle belongs to last cycle's pc; a same-cycle
      // redirect means that instruction is on the wrong path.
      fetch_pc_q   <= pc_q;
      inst_valid_q <= (state_q == RUN) && !branch_valid;

      case (state_q)
        IDLE: begin
          if (enable) state_q <= RUN;
        end
        RUN: begin
          if (branch_valid && !target_legal) begin
            state_q <= FAULT;
          end else if (branch_valid) begin
            pc_q    <= branch_target;
            state_q <= enable ? RUN : IDLE;
          end else if (!enable) begin
            state_q <= IDLE;
          end else if (!stall) begin
            if (pc_q == LAST_PC) state_q <= DONE;
            else                 pc_q    <= pc_q + PC_STEP;
          end
        end
        DONE: begin
          if (branch_valid) begin
            if (target_legal) begin
              pc_q    <= branch_target;
              state_q <= RUN;
            end else begin
              state_q <= FAULT;
            end
          end else if (!enable) begin
            state_q <= IDLE;
          end
        end
        default: ;  // FAULT is sticky until reset
      endcase
    end
  end

  assign pc         = pc_q;
  assign fetch_pc   = fetch_pc_q;
  assign pc_plus8   = fetch_pc_q + R15_OFS;
  assign inst_valid = inst_valid_q;
  assign ready      = (state_q == RUN) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign fault      = (state_q == FAULT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random stimulus,
// all compared every cycle against a word-index reference model.
module tb_pc_unit;

  localparam int W          = 32;
  localparam int INST_COUNT = 256;
  localparam int RESET_PC   = 0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         stall = 1'b0;
  logic         branch_valid = 1'b0;
  logic [W-1:0] branch_target = '0;
  logic [W-1:0] pc, fetch_pc, pc_plus8;
  logic         inst_valid, ready, done, fault;

  pc_unit #(.BIT_WIDTH(W), .INST_COUNT(INST_COUNT), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .pc           (pc),
    .fetch_pc     (fetch_pc),
    .pc_plus8     (pc_plus8),
    .inst_valid   (inst_valid),
    .ready        (ready),
    .done         (done),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the PC is tracked as an instruction index into code memory.
  typedef enum {M_IDLE, M_RUN, M_DONE, M_FAULT} mstate_e;
  mstate_e     m_state = M_IDLE;
  int unsigned m_idx   = RESET_PC / 4;
  longint      m_fpc   = 0;
  bit          m_valid = 1'b0;

  function automatic bit legal(input logic [W-1:0] t);
    longint unsigned tl = longint'(t);
    return (tl % 4 == 0) && (tl / 4 < INST_COUNT);
  endfunction

  task automatic model_update(input bit rst, input bit en, input bit st,
                              input bit bv, input logic [W-1:0] bt);
    if (rst) begin
      m_state = M_IDLE;
      m_idx   = RESET_PC / 4;
      m_fpc   = 0;
      m_valid = 1'b0;
      return;
    end
    m_fpc   = longint'(m_idx) * 4;
    m_valid = (m_state == M_RUN) && !bv;
    case (m_state)
      M_IDLE: if (en) m_state = M_RUN;
      M_RUN: begin
        if (bv && !legal(bt))   m_state = M_FAULT;
        else if (bv) begin
          m_idx   = int'(bt) / 4;
          m_state = en ? M_RUN : M_IDLE;
        end
        else if (!en)           m_state = M_IDLE;
        else if (st)            ;
        else if (m_idx == INST_COUNT - 1) m_state = M_DONE;
        else                    m_idx++;
      end
      M_DONE: begin
        if (bv) begin
          if (legal(bt)) begin
            m_idx   = int'(bt) / 4;
            m_state = M_RUN;
          end else begin
            m_state = M_FAULT;
          end
        end else if (!en) m_state = M_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pc",         pc,         W'(longint'(m_idx) * 4));
    check("fetch_pc",   fetch_pc,   W'(m_fpc));
    check("pc_plus8",   pc_plus8,   W'(m_fpc + 8));
    check("inst_valid", W'(inst_valid), W'(m_valid));
    check("ready",      W'(ready),  W'((m_state == M_RUN) || (m_state == M_DONE)));
    check("done",       W'(done),   W'(m_state == M_DONE));
    check("fault",      W'(fault),  W'(m_state == M_FAULT));
  endtask

  task automatic step(input bit rst, input bit en, input bit st,
                      input bit bv, input logic [W-1:0] bt);
    reset = rst; enable = en; stall = st; branch_valid = bv; branch_target = bt;
    @(posedge clk);
    model_update(rst, en, st, bv, bt);
    #1;
    compare_all();
  endtask

  task automatic run_to(input int unsigned word);
    for (int i = 0; i < 400 && m_idx != word; i++) step(0, 1, 0, 0, '0);
  endtask

  initial begin
    // Reset and plain sequential run
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    check("reset_pc_plus8", pc_plus8, 32'h8);
    run_to(32'h10 / 4);

    // Three-cycle stall at 0x10
    repeat (3) step(0, 1, 1, 0, '0);
    check("stall_fetch_pc", fetch_pc, 32'h10);
    run_to(32'h18 / 4);

    // Branch overrides a simultaneous stall: one bubble
    step(0, 1, 1, 1, 32'h40);
    check("redirect_bubble", W'(inst_valid), 32'h0);
    step(0, 1, 0, 0, '0);
    check("redirect_tag", fetch_pc, 32'h40);
    repeat (2) step(0, 1, 0, 0, '0);

    // Drop enable at 0x8, resume two cycles later
    step(0, 1, 0, 1, 32'h0);
    run_to(32'h8 / 4);
    repeat (2) step(0, 0, 0, 0, '0);
    check("idle_hold_pc", pc, 32'h8);
    repeat (4) step(0, 1, 0, 0, '0);

    // End of memory, then a branch from DONE back into RUN
    step(0, 1, 0, 1, 32'h3F0);
    repeat (8) step(0, 1, 0, 0, '0);
    check("done_pc", pc, 32'h3FC);
    step(0, 1, 0, 1, 32'h0);
    repeat (3) step(0, 1, 0, 0, '0);

    // Misaligned target faults; sticky until reset
    step(0, 1, 0, 1, 32'h22);
    repeat (3) step(0, 1, 0, 1, 32'h40);
    step(1, 1, 0, 0, '0);
    repeat (4) step(0, 1, 0, 0, '0);

    // Out-of-range target faults
    step(0, 1, 0, 1, 32'h400);
    repeat (2) step(0, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);

    // Reset in the middle of a run
    repeat (6) step(0, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    check("midrun_rst_pc", pc, W'(RESET_PC));
    check("midrun_rst_fetch", fetch_pc, 32'h0);
    check("midrun_rst_ready", W'(ready), 32'h0);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      bit          r_rst, r_en, r_st, r_bv;
      logic [W-1:0] r_bt;
      int unsigned kind;
      r_rst = ($urandom_range(99) == 0) || (m_state == M_FAULT && $urandom_range(7) == 0);
      r_en  = ($urandom_range(9) != 0);
      r_st  = ($urandom_range(4) == 0);
      r_bv  = ($urandom_range(9) == 0);
      kind  = $urandom_range(9);
      if (kind <= 5)      r_bt = W'($urandom_range(INST_COUNT - 1) * 4);
      else if (kind == 6) r_bt = W'($urandom_range(INST_COUNT - 1, INST_COUNT - 4) * 4);
      else if (kind == 7) r_bt = W'($urandom_range(INST_COUNT * 4 - 1)) | 32'h1;
      else if (kind == 8) r_bt = W'(INST_COUNT * 4 + $urandom_range(1023) * 4);
      else                r_bt = W'($urandom);
      step(r_rst, r_en, r_st, r_bv, r_bt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
